mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single memory bus port between instruction fetch and data load/store.
//  Sits between the fetch stage/memory stage and busio; one transaction outstanding at a time.
//  Sequences each access as request -> grant -> mem_ready -> response pulse.
//  Returns per-requester stall so hazard can freeze the pipeline while an access is pending.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles a granted access waits for mem_ready (BUS_TIMEOUT_EN only)
// PORTS
//  clk          in   1   clock, all state on posedge
//  reset        in   1   asynchronous, active-high; clears all state immediately
//  ifetch_req   in   1   fetch wants instruction at ifetch_addr; held until ifetch_ready
//  ifetch_addr  in   32  instruction address
//  ifetch_rdata out  32  instruction word, valid with ifetch_ready
//  ifetch_ready out  1   1-cycle completion pulse for fetch
//  ifetch_stall out  1   ifetch_req high and ifetch_ready low this cycle
//  data_req     in   1   memory stage access request; held until data_ready
//  data_we      in   1   1=store, 0=load
//  data_addr    in   32  data address
//  data_wdata   in   32  store data
//  data_wstrb   in   4   byte strobes (store only)
//  data_rdata   out  32  load data, valid with data_ready
//  data_ready   out  1   1-cycle completion pulse for data
//  data_stall   out  1   data_req high and data_ready low this cycle
//  mem_valid    out  1   bus request; held high until mem_ready
//  mem_we / mem_addr[32] / mem_wdata[32] / mem_wstrb[4]  out  bus command, stable while mem_valid
//  mem_ready    in   1   bus completes access this cycle
//  mem_rdata    in   32  bus read data, sampled when mem_valid && mem_ready
//  bus_error    out  1   1-cycle pulse with the ready pulse of a timed-out access
// BEHAVIOUR
//  Reset (async): state=IDLE; mem_valid, ifetch_ready, data_ready, bus_error = 0;
//   rdata regs = 0; mem_* command regs = 0; fairness flag = 0; timeout counter = 0.
//  States: IDLE, GNT_I (fetch owns bus), GNT_D (data owns bus).
//  IDLE: data_req -> GNT_D; else ifetch_req -> GNT_I. Command latched at grant edge.
//  Priority: data over fetch, except when fairness flag set (a data access just
//   completed while ifetch_req was pending) -> fetch granted next; flag clears on grant.
//  GNT_x: mem_valid=1 from cycle after request; command regs frozen.
//   On mem_valid&&mem_ready: capture mem_rdata into x_rdata, pulse x_ready next cycle,
//   return to IDLE (no back-to-back grant; minimum 1 IDLE cycle between accesses).
//  Latency: req at cycle N, mem_valid N+1; mem_ready at M -> x_ready at M+1. Best case 2.
//  Stores: data_rdata = 0 on completion; mem_wstrb forced 0 for loads and fetches.
//  Requester dropping req mid-access: access still completes on bus; ready still pulses.
//  ready/stall: outputs are registered ready pulses; stall is combinational (req & ~ready).
//  mem_ready while mem_valid=0: ignored.
//  Reset mid-access: mem_valid drops asynchronously; no ready pulse is issued.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined: counter (clog2(TIMEOUT_CYCLES+1) bits) increments each GNT_x
//   cycle with mem_ready=0, clears on entering GNT_x; at count==TIMEOUT_CYCLES the access
//   aborts: mem_valid drops, x_ready and bus_error pulse together, x_rdata=0, go IDLE.
//  BUS_TIMEOUT_EN undefined: waits indefinitely for mem_ready; bus_error tied 0; no counter.
// STRUCTURE
//  Shared package: state encoding (IDLE/GNT_I/GNT_D), bus width constants (32 addr/data, 4 strobe).
//  Single module; no sub-module (FSM plus command/response registers only).
// TESTING
//  Fetch only, mem_ready 1 cycle after mem_valid, addr 0x8000_0000 -> ifetch_ready 3 cycles after req, rdata=mem_rdata.
//  ifetch_req and data_req (load 0x1000) both high in IDLE -> data granted first; fetch granted next via fairness.
//  Store 0x2000 wdata 0xDEADBEEF wstrb 0x3 -> mem_we=1, mem_wstrb=0x3, data_rdata=0, data_ready pulse once.
//  mem_ready held low 5 cycles -> mem_* command stable all 5, ifetch_stall high until ready pulse.
//  reset asserted mid GNT_D -> mem_valid 0 same cycle, no data_ready, IDLE after release.
//  BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready never -> after 8 waits data_ready+bus_error pulse, rdata=0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and bus widths for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntI = 2'd1,
    StGntD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one memory bus port between instruction fetch and data load/store.
// Define BUS_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES for mem_ready.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifetch_req,
  input  logic [ADDR_W-1:0] ifetch_addr,
  output logic [DATA_W-1:0] ifetch_rdata,
  output logic              ifetch_ready,
  output logic              ifetch_stall,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [STRB_W-1:0] data_wstrb,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ready,
  output logic              data_stall,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_error
);

  arb_state_e        state_q;
  logic              mem_valid_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [STRB_W-1:0] mem_wstrb_q;
  logic [DATA_W-1:0] ifetch_rdata_q;
  logic [DATA_W-1:0] data_rdata_q;
  logic              ifetch_ready_q;
  logic              data_ready_q;
  logic              fair_q;

  logic              pick_i;
  logic              pick_d;
  logic              timeout;
  logic              finish;
  logic [DATA_W-1:0] resp_data;

  // Fetch wins only when data is idle or fetch was starved by the last data access.
  assign pick_i = ifetch_req & (fair_q | ~data_req);
  assign pick_d = data_req & ~pick_i;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] wait_cnt_q;
  logic            bus_error_q;

  // Abort on the wait cycle that would bring the count up to TIMEOUT_CYCLES.
  assign timeout   = mem_valid_q & ~mem_ready & (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign bus_error = bus_error_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign bus_error          = 1'b0;
`endif

  assign finish    = (mem_valid_q & mem_ready) | timeout;
  assign resp_data = timeout ? '0 : mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      mem_valid_q    <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_wstrb_q    <= '0;
      ifetch_rdata_q <= '0;
      data_rdata_q   <= '0;
      ifetch_ready_q <= 1'b0;
      data_ready_q   <= 1'b0;
      fair_q         <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      wait_cnt_q     <= '0;
      bus_error_q    <= 1'b0;
`endif
    end else begin
      ifetch_ready_q <= 1'b0;
      data_ready_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      bus_error_q    <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (pick_i) begin
            state_q     <= StGntI;
            mem_valid_q <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ifetch_addr;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            fair_q      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
          end else if (pick_d) begin
            state_q     <= StGntD;
            mem_valid_q <= 1'b1;
            mem_we_q    <= data_we;
            mem_addr_q  <= data_addr;
            mem_wdata_q <= data_wdata;
            mem_wstrb_q <= data_we ? data_wstrb : '0;
            fair_q      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
          end
        end
        StGntI, StGntD: begin
          if (finish) begin
            state_q     <= StIdle;
            mem_valid_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            bus_error_q <= timeout;
`endif
            if (state_q == StGntI) begin
              ifetch_rdata_q <= resp_data;
              ifetch_ready_q <= 1'b1;
            end else begin
              data_rdata_q <= mem_we_q ? '0 : resp_data;
              data_ready_q <= 1'b1;
              fair_q       <= ifetch_req;
            end
          end
`ifdef BUS_TIMEOUT_EN
          else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
`endif
        end
        default: begin
          state_q     <= StIdle;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_valid    = mem_valid_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign ifetch_rdata = ifetch_rdata_q;
  assign data_rdata   = data_rdata_q;
  assign ifetch_ready = ifetch_ready_q;
  assign data_ready   = data_ready_q;
  assign ifetch_stall = ifetch_req & ~ifetch_ready_q;
  assign data_stall   = data_req & ~data_ready_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter (optional BUS_TIMEOUT_EN section).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifetch_req;
  logic [31:0] ifetch_addr;
  logic [31:0] ifetch_rdata;
  logic        ifetch_ready;
  logic        ifetch_stall;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        data_stall;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_error;

  int n_checks = 0;
  int n_err    = 0;

  // Transaction-level reference state for the random phase.
  int          owner, owner_new, waitc;
  bit          fair_m, i_out, d_out, i_prev, d_prev, rdy_drv, exp_i_rdy, exp_d_rdy;
  bit          d_we_m, cmd_we;
  logic [31:0] i_addr_m, d_addr_m, d_wdata_m, cmd_addr, cmd_wdata, i_rd_exp, d_rd_exp, rd;
  logic [3:0]  d_wstrb_m, cmd_wstrb;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ifetch_req  (ifetch_req),
    .ifetch_addr (ifetch_addr),
    .ifetch_rdata(ifetch_rdata),
    .ifetch_ready(ifetch_ready),
    .ifetch_stall(ifetch_stall),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_wstrb  (data_wstrb),
    .data_rdata  (data_rdata),
    .data_ready  (data_ready),
    .data_stall  (data_stall),
    .mem_valid   (mem_valid),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .bus_error   (bus_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    ifetch_req  = 1'b0;
    ifetch_addr = '0;
    data_req    = 1'b0;
    data_we     = 1'b0;
    data_addr   = '0;
    data_wdata  = '0;
    data_wstrb  = '0;
    mem_ready   = 1'b0;
    mem_rdata   = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_mem_valid", mem_valid, 0);
    check("rst_ifetch_ready", ifetch_ready, 0);
    check("rst_data_ready", data_ready, 0);
    check("rst_bus_error", bus_error, 0);
    check("rst_ifetch_rdata", ifetch_rdata, 0);
    check("rst_data_rdata", data_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    reset = 1'b0;
    @(negedge clk);

    // Fetch only: ready 3 cycles after request
    ifetch_req  = 1'b1;
    ifetch_addr = 32'h8000_0000;
    @(negedge clk);
    check("f_valid", mem_valid, 1);
    check("f_addr", mem_addr, 32'h8000_0000);
    check("f_we", mem_we, 0);
    check("f_wstrb", mem_wstrb, 0);
    check("f_stall_c1", ifetch_stall, 1);
    check("f_ready_c1", ifetch_ready, 0);
    @(negedge clk);
    check("f_ready_c2", ifetch_ready, 0);
    check("f_valid_c2", mem_valid, 1);
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("f_ready_c3", ifetch_ready, 1);
    check("f_rdata", ifetch_rdata, 32'h1234_5678);
    check("f_valid_c3", mem_valid, 0);
    check("f_stall_c3", ifetch_stall, 0);
    ifetch_req = 1'b0;
    mem_ready  = 1'b0;
    @(negedge clk);
    check("f_ready_c4", ifetch_ready, 0);
    check("f_valid_c4", mem_valid, 0);
    mem_ready = 1'b1;  // spurious ready while idle
    @(negedge clk);
    check("spur_valid", mem_valid, 0);
    check("spur_ifetch_ready", ifetch_ready, 0);
    check("spur_data_ready", data_ready, 0);
    mem_ready = 1'b0;

    // Both request: data first, then fetch via fairness despite a new data request
    ifetch_req  = 1'b1;
    ifetch_addr = 32'h8000_0010;
    data_req    = 1'b1;
    data_we     = 1'b0;
    data_addr   = 32'h0000_1000;
    data_wstrb  = 4'hF;
    @(negedge clk);
    check("pri_valid", mem_valid, 1);
    check("pri_addr", mem_addr, 32'h0000_1000);
    check("pri_we", mem_we, 0);
    check("pri_load_wstrb", mem_wstrb, 0);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    check("pri_d_ready", data_ready, 1);
    check("pri_d_rdata", data_rdata, 32'hCAFE_0001);
    check("pri_valid_gap", mem_valid, 0);
    check("pri_i_stall", ifetch_stall, 1);
    check("pri_d_stall", data_stall, 0);
    data_addr = 32'h0000_1004;
    mem_ready = 1'b0;
    @(negedge clk);
    check("fair_valid", mem_valid, 1);
    check("fair_addr", mem_addr, 32'h8000_0010);
    check("fair_d_stall", data_stall, 1);
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    check("fair_i_ready", ifetch_ready, 1);
    check("fair_i_rdata", ifetch_rdata, 32'h0BAD_F00D);
    ifetch_req = 1'b0;
    mem_ready  = 1'b0;
    @(negedge clk);
    check("fair_d2_addr", mem_addr, 32'h0000_1004);
    check("fair_d2_valid", mem_valid, 1);
    mem_ready = 1'b1;
    mem_rdata = 32'h55AA_55AA;
    @(negedge clk);
    check("fair_d2_ready", data_ready, 1);
    check("fair_d2_rdata", data_rdata, 32'h55AA_55AA);
    data_req  = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);

`ifdef BUS_TIMEOUT_EN
    // Timeout: mem_ready never arrives
    data_req  = 1'b1;
    data_we   = 1'b0;
    data_addr = 32'h0000_4000;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("to_valid", mem_valid, 1);
      check("to_ready_early", data_ready, 0);
      check("to_err_early", bus_error, 0);
    end
    @(negedge clk);
    check("to_ready", data_ready, 1);
    check("to_bus_error", bus_error, 1);
    check("to_rdata", data_rdata, 0);
    check("to_valid_drop", mem_valid, 0);
    data_req = 1'b0;
    @(negedge clk);
    check("to_err_once", bus_error, 0);
    check("to_ready_once", data_ready, 0);
`endif

    // Store
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_addr  = 32'h0000_2000;
    data_wdata = 32'hDEAD_BEEF;
    data_wstrb = 4'h3;
    @(negedge clk);
    check("st_valid", mem_valid, 1);
    check("st_we", mem_we, 1);
    check("st_wstrb", mem_wstrb, 4'h3);
    check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("st_addr", mem_addr, 32'h0000_2000);
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("st_ready", data_ready, 1);
    check("st_rdata", data_rdata, 0);
    data_req  = 1'b0;
    data_we   = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    check("st_ready_once", data_ready, 0);
    check("st_valid_done", mem_valid, 0);

    // Slow bus: command stable while waiting
    ifetch_req  = 1'b1;
    ifetch_addr = 32'h8000_0100;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("slow_valid", mem_valid, 1);
      check("slow_addr", mem_addr, 32'h8000_0100);
      check("slow_we", mem_we, 0);
      check("slow_stall", ifetch_stall, 1);
      check("slow_ready", ifetch_ready, 0);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h600D_CAFE;
    @(negedge clk);
    check("slow_done", ifetch_ready, 1);
    check("slow_stall_rel", ifetch_stall, 0);
    check("slow_rdata", ifetch_rdata, 32'h600D_CAFE);
    ifetch_req = 1'b0;
    mem_ready  = 1'b0;
    @(negedge clk);

    // Reset in the middle of a data grant
    data_req  = 1'b1;
    data_addr = 32'h0000_3000;
    @(negedge clk);
    check("rm_valid", mem_valid, 1);
    check("rm_addr", mem_addr, 32'h0000_3000);
    #1 reset = 1'b1;
    #1 check("rm_async_drop", mem_valid, 0);
    @(negedge clk);
    check("rm_no_ready", data_ready, 0);
    reset    = 1'b0;
    data_req = 1'b0;
    @(negedge clk);
    check("rm_idle_valid", mem_valid, 0);
    check("rm_idle_ready", data_ready, 0);
    check("rm_rdata_clr", ifetch_rdata, 0);

    // Randomized traffic against the transaction-level model
    owner   = 0;
    fair_m  = 0;
    i_out   = 0;
    d_out   = 0;
    i_prev  = 0;
    d_prev  = 0;
    rdy_drv = 0;
    waitc   = 0;
    cmd_we  = 0;
    i_rd_exp = '0;
    d_rd_exp = '0;
    cmd_addr = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      exp_i_rdy = 0;
      exp_d_rdy = 0;
      owner_new = owner;
      if (owner != 0 && rdy_drv) begin
        if (owner == 1) exp_i_rdy = 1;
        else begin
          exp_d_rdy = 1;
          fair_m    = i_prev;
        end
        owner_new = 0;
      end else if (owner == 0) begin
        if (d_prev && !(fair_m && i_prev)) owner_new = 2;
        else if (i_prev) owner_new = 1;
        if (owner_new == 1) begin
          cmd_addr  = i_addr_m;
          cmd_we    = 0;
          cmd_wstrb = '0;
        end else if (owner_new == 2) begin
          cmd_addr  = d_addr_m;
          cmd_we    = d_we_m;
          cmd_wstrb = d_we_m ? d_wstrb_m : 4'h0;
          cmd_wdata = d_wdata_m;
        end
        if (owner_new != 0) begin
          fair_m = 0;
          waitc  = $urandom_range(0, 4);
        end
      end

      check("rnd_i_ready", ifetch_ready, exp_i_rdy);
      check("rnd_d_ready", data_ready, exp_d_rdy);
      if (exp_i_rdy) check("rnd_i_rdata", ifetch_rdata, i_rd_exp);
      if (exp_d_rdy) check("rnd_d_rdata", data_rdata, d_rd_exp);
      check("rnd_valid", mem_valid, owner_new != 0);
      if (owner_new != 0) begin
        check("rnd_addr", mem_addr, cmd_addr);
        check("rnd_we", mem_we, cmd_we);
        check("rnd_wstrb", mem_wstrb, cmd_wstrb);
        if (cmd_we) check("rnd_wdata", mem_wdata, cmd_wdata);
      end
      check("rnd_i_stall", ifetch_stall, i_out && !exp_i_rdy);
      check("rnd_d_stall", data_stall, d_out && !exp_d_rdy);
      check("rnd_bus_error", bus_error, 0);

      if (owner_new != 0) begin
        if (waitc == 0) begin
          rd        = $urandom;
          mem_ready = 1'b1;
          mem_rdata = rd;
          if (owner_new == 1) i_rd_exp = rd;
          else d_rd_exp = cmd_we ? 32'h0 : rd;
          rdy_drv = 1;
        end else begin
          waitc--;
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          rdy_drv   = 0;
        end
      end else begin
        mem_ready = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
        rdy_drv   = 0;
      end

      if (exp_i_rdy) i_out = 0;
      if (exp_d_rdy) d_out = 0;
      if (!i_out && $urandom_range(0, 2) != 0) begin
        i_out    = 1;
        i_addr_m = {1'b1, 29'($urandom), 2'b00};
      end
      if (!d_out && $urandom_range(0, 2) != 0) begin
        d_out     = 1;
        d_addr_m  = {1'b0, 29'($urandom), 2'b00};
        d_we_m    = 1'($urandom_range(0, 1));
        d_wdata_m = $urandom;
        d_wstrb_m = 4'($urandom);
      end
      ifetch_req  = i_out;
      ifetch_addr = i_addr_m;
      data_req    = d_out;
      data_we     = d_we_m;
      data_addr   = d_addr_m;
      data_wdata  = d_wdata_m;
      data_wstrb  = d_wstrb_m;
      i_prev      = i_out;
      d_prev      = d_out;
      owner       = owner_new;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
